// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller.
package pc_redirect_ctrl_pkg;

    // Redirect sequencing states: wait for a redirect, kill the younger
    // stages, then offer the captured target to fetch.
    typedef enum logic [1:0] {
        redir_idle     = 2'd0,
        redir_flush    = 2'd1,
        redir_redirect = 2'd2
    } rv32_redirect_state;

    localparam int unsigned REDIR_ADDR_W = 32;
    localparam int unsigned REDIR_CNT_W  = 4;

    // Legal range for the flush length; the counter is 4 bits wide.
    localparam int unsigned FLUSH_CYCLES_MIN = 1;
    localparam int unsigned FLUSH_CYCLES_MAX = 15;

    function automatic bit flush_cycles_legal(input int unsigned n);
        return (n >= FLUSH_CYCLES_MIN) && (n <= FLUSH_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: grants interrupts at an instruction boundary,
// captures the branch unit's resolved target, flushes IF/ID for a fixed
// number of cycles and then hands the target to fetch via valid/ready.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ex_valid,
    input  logic                    i_int_pending,
    input  logic [REDIR_ADDR_W-1:0] i_int_vector,
    output logic                    o_int_taken,
    output logic [REDIR_ADDR_W-1:0] o_int_addr,
    output logic                    o_int_ack,
    input  logic                    i_branch_taken,
    input  logic [REDIR_ADDR_W-1:0] i_branch_addr,
    output logic                    o_flush,
    output logic                    o_fetch_hold,
    output logic                    o_redirect_valid,
    output logic [REDIR_ADDR_W-1:0] o_redirect_addr,
    input  logic                    i_redirect_ready,
    output logic                    o_busy
);

    // Reject an unsupported flush length when the design is elaborated.
    generate
        if (!flush_cycles_legal(FLUSH_CYCLES)) begin : g_bad_flush_cycles
            $error("pc_redirect_ctrl: FLUSH_CYCLES must be in 1..15");
        end
    endgenerate

    // Counter load value: FLUSH reaches zero after FLUSH_CYCLES cycles.
    localparam logic [REDIR_CNT_W-1:0] FLUSH_LOAD = REDIR_CNT_W'(FLUSH_CYCLES - 1);

    rv32_redirect_state      state_q, state_d;
    logic [REDIR_CNT_W-1:0]  cnt_q, cnt_d;
    logic [REDIR_ADDR_W-1:0] addr_q, addr_d;
    logic                    int_flag_q, int_flag_d;
    logic                    ack_q, ack_d;

    // Interrupt grant is a pure function of state and interrupt inputs, so
    // the branch unit can feed it back as i_branch_taken without a loop.
    logic int_grant;
    assign int_grant = (state_q == redir_idle) & i_int_pending & i_ex_valid;

    // State, counter, target and interrupt-flag registers; reset wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= redir_idle;
            cnt_q      <= '0;
            addr_q     <= '0;
            int_flag_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            int_flag_q <= int_flag_d;
            ack_q      <= ack_d;
        end
    end

    // Next-state logic: capture in IDLE, count down in FLUSH, wait for the
    // fetch handshake in REDIRECT. Redirect requests outside IDLE are
    // wrong-path and dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        int_flag_d = int_flag_q;
        ack_d      = 1'b0;
        unique case (state_q)
            redir_idle: begin
                if (i_branch_taken) begin
                    addr_d     = i_branch_addr;
                    int_flag_d = int_grant;
                    ack_d      = int_grant;
                    cnt_d      = FLUSH_LOAD;
                    state_d    = redir_flush;
                end
            end
            redir_flush: begin
                if (cnt_q == '0) begin
                    state_d = redir_redirect;
                end else begin
                    cnt_d = cnt_q - REDIR_CNT_W'(1);
                end
            end
            redir_redirect: begin
                if (i_redirect_ready) begin
                    int_flag_d = 1'b0;
                    state_d    = redir_idle;
                end
            end
            default: begin
                state_d = redir_idle;
            end
        endcase
    end

    // Output decode from the registered state; target register is always
    // visible so fetch sees a stable address throughout REDIRECT.
    always_comb begin
        o_int_taken      = int_grant;
        o_int_addr       = i_int_vector;
        o_int_ack        = ack_q & int_flag_q;
        o_flush          = (state_q == redir_flush);
        o_fetch_hold     = (state_q == redir_flush) | (state_q == redir_redirect);
        o_redirect_valid = (state_q == redir_redirect);
        o_redirect_addr  = addr_q;
        o_busy           = (state_q != redir_idle);
    end

endmodule
